// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the two-master arbiter slice.
//  - Data/select widths for the 32-bit Wishbone ports.
//  - Arbiter FSM state type.
//  - pick_master: round-robin choice between two cycle requests.
package wb_pkg;

  localparam int WB_DATA_WIDTH = 32;
  localparam int WB_SEL_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    TURN = 2'd3
  } arb_state_t;

  // Returns the index of the master to grant. On a tie the master that was
  // not served last wins; otherwise the single requester wins.
  function automatic logic pick_master(input logic req0, input logic req1, input logic last);
    logic idx;
    if (req0 && req1) begin
      idx = ~last;
    end else if (req1) begin
      idx = 1'b1;
    end else begin
      idx = 1'b0;
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_outstanding_cnt.sv
// Saturating up/down counter of accepted-but-unacknowledged requests.
// Ports:
//  i_clk    clock
//  i_rst_n  synchronous reset, active low
//  i_clr    synchronous clear (bus cycle aborted or not owned)
//  i_inc    one request accepted this cycle
//  i_dec    one ack consumed this cycle
//  o_full   count equals MAX_COUNT
//  o_empty  count equals zero
module wb_outstanding_cnt
  import wb_pkg::*;
#(
  parameter int MAX_COUNT = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full,
  output logic o_empty
);

  localparam int            CW    = $clog2(MAX_COUNT + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_COUNT);

  logic [CW-1:0] cnt_r;

  // Count state: clear wins, simultaneous inc/dec cancel, never wraps.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (i_clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (i_inc && !i_dec && (cnt_r != MAX_C)) begin
      cnt_r <= cnt_r + CW'(1);
    end else if (i_dec && !i_inc && (cnt_r != {CW{1'b0}})) begin
      cnt_r <= cnt_r - CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Flags decoded from the registered count.
  always_comb begin
    o_full  = (cnt_r == MAX_C);
    o_empty = (cnt_r == {CW{1'b0}});
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master round-robin arbiter for pipelined Wishbone.
// Ownership is granted per bus cycle (cyc assertion) and never pre-empted.
// Each owner's outstanding requests are capped at MAX_OUTSTANDING so that
// acks can be routed back to the owner without a tag.
// Ports:
//  i_clk, i_rst_n                 clock, synchronous active-low reset
//  i_mN_wb_*  / o_mN_wb_*         master N (N = 0,1) Wishbone slave-side port
//  o_s_wb_*   / i_s_wb_*          shared Wishbone master-side port to the slave
module wb_arbiter2
  import wb_pkg::*;
#(
  parameter int WB_ADDR_WIDTH   = 30,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  // master 0
  input  logic                     i_m0_wb_cyc,
  input  logic                     i_m0_wb_stb,
  output logic                     o_m0_wb_stall,
  output logic                     o_m0_wb_ack,
  input  logic                     i_m0_wb_we,
  input  logic [WB_ADDR_WIDTH-1:0] i_m0_wb_addr,
  input  logic [WB_DATA_WIDTH-1:0] i_m0_wb_data,
  input  logic [WB_SEL_WIDTH-1:0]  i_m0_wb_sel,
  output logic [WB_DATA_WIDTH-1:0] o_m0_wb_data,
  // master 1
  input  logic                     i_m1_wb_cyc,
  input  logic                     i_m1_wb_stb,
  output logic                     o_m1_wb_stall,
  output logic                     o_m1_wb_ack,
  input  logic                     i_m1_wb_we,
  input  logic [WB_ADDR_WIDTH-1:0] i_m1_wb_addr,
  input  logic [WB_DATA_WIDTH-1:0] i_m1_wb_data,
  input  logic [WB_SEL_WIDTH-1:0]  i_m1_wb_sel,
  output logic [WB_DATA_WIDTH-1:0] o_m1_wb_data,
  // slave
  output logic                     o_s_wb_cyc,
  output logic                     o_s_wb_stb,
  input  logic                     i_s_wb_stall,
  input  logic                     i_s_wb_ack,
  output logic                     o_s_wb_we,
  output logic [WB_ADDR_WIDTH-1:0] o_s_wb_addr,
  output logic [WB_DATA_WIDTH-1:0] o_s_wb_data,
  output logic [WB_SEL_WIDTH-1:0]  o_s_wb_sel,
  input  logic [WB_DATA_WIDTH-1:0] i_s_wb_data
);

  arb_state_t state_r;
  logic       last_r;       // index of the master served most recently
  logic       pick_s;
  logic       own_any_s;
  logic       own_cyc_s;
  logic       own_stb_s;
  logic       full_s;
  logic       empty_s;
  logic       mst_stall_s;
  logic       ack_ok_s;
  logic       accept_s;
  logic       clr_s;

  // Arbiter FSM: grant is registered, so cyc seen in IDLE yields slave cyc
  // one cycle later; TURN forces one dead bus cycle between owners.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_m0_wb_cyc || i_m1_wb_cyc) begin
            state_r <= pick_s ? OWN1 : OWN0;
            last_r  <= pick_s;
          end else begin
            state_r <= IDLE;
            last_r  <= last_r;
          end
        end
        OWN0: begin
          state_r <= i_m0_wb_cyc ? OWN0 : TURN;
          last_r  <= last_r;
        end
        OWN1: begin
          state_r <= i_m1_wb_cyc ? OWN1 : TURN;
          last_r  <= last_r;
        end
        TURN: begin
          state_r <= IDLE;
          last_r  <= last_r;
        end
        default: begin
          state_r <= IDLE;
          last_r  <= last_r;
        end
      endcase
    end
  end

  // Round-robin choice for the next grant.
  always_comb begin
    pick_s = pick_master(i_m0_wb_cyc, i_m1_wb_cyc, last_r);
  end

  // Request mux from the owning master; nothing is driven when unowned.
  always_comb begin
    own_any_s   = 1'b0;
    own_cyc_s   = 1'b0;
    own_stb_s   = 1'b0;
    o_s_wb_we   = 1'b0;
    o_s_wb_addr = {WB_ADDR_WIDTH{1'b0}};
    o_s_wb_data = {WB_DATA_WIDTH{1'b0}};
    o_s_wb_sel  = {WB_SEL_WIDTH{1'b0}};
    case (state_r)
      OWN0: begin
        own_any_s   = 1'b1;
        own_cyc_s   = i_m0_wb_cyc;
        own_stb_s   = i_m0_wb_stb;
        o_s_wb_we   = i_m0_wb_we;
        o_s_wb_addr = i_m0_wb_addr;
        o_s_wb_data = i_m0_wb_data;
        o_s_wb_sel  = i_m0_wb_sel;
      end
      OWN1: begin
        own_any_s   = 1'b1;
        own_cyc_s   = i_m1_wb_cyc;
        own_stb_s   = i_m1_wb_stb;
        o_s_wb_we   = i_m1_wb_we;
        o_s_wb_addr = i_m1_wb_addr;
        o_s_wb_data = i_m1_wb_data;
        o_s_wb_sel  = i_m1_wb_sel;
      end
      default: begin
        own_any_s = 1'b0;
      end
    endcase
  end

  // Slave handshake and owner/non-owner stall and ack routing.
  // stb without cyc is ignored, and stb is withheld at the outstanding cap.
  always_comb begin
    o_s_wb_cyc    = own_cyc_s;
    o_s_wb_stb    = own_cyc_s && own_stb_s && !full_s;
    mst_stall_s   = i_s_wb_stall || full_s;
    ack_ok_s      = own_any_s && i_s_wb_ack && !empty_s;
    accept_s      = o_s_wb_stb && !i_s_wb_stall;
    // Clearing whenever the owned cycle is not active aborts on cyc drop.
    clr_s         = !own_cyc_s;
    o_m0_wb_stall = (state_r == OWN0) ? mst_stall_s : 1'b1;
    o_m1_wb_stall = (state_r == OWN1) ? mst_stall_s : 1'b1;
    o_m0_wb_ack   = (state_r == OWN0) && ack_ok_s;
    o_m1_wb_ack   = (state_r == OWN1) && ack_ok_s;
    o_m0_wb_data  = i_s_wb_data;
    o_m1_wb_data  = i_s_wb_data;
  end

  wb_outstanding_cnt #(
    .MAX_COUNT (MAX_OUTSTANDING)
  ) u_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (clr_s),
    .i_inc   (accept_s),
    .i_dec   (ack_ok_s),
    .o_full  (full_s),
    .o_empty (empty_s)
  );

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: a hand-derived vector table, memory
// backed scenarios with a pipelined slave model, and randomized traffic, all
// compared against a transaction-level reference model.
module tb_wb_arbiter2;

  localparam int AW   = 30;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          m0_cyc, m0_stb, m0_we, m0_stall, m0_ack;
  logic [AW-1:0] m0_addr;
  logic [31:0]   m0_wdat, m0_rdat;
  logic [3:0]    m0_sel;
  logic          m1_cyc, m1_stb, m1_we, m1_stall, m1_ack;
  logic [AW-1:0] m1_addr;
  logic [31:0]   m1_wdat, m1_rdat;
  logic [3:0]    m1_sel;
  logic          s_cyc, s_stb, s_stall, s_ack, s_we;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_wdat, s_rdat;
  logic [3:0]    s_sel;

  wb_arbiter2 #(.WB_ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m0_wb_cyc(m0_cyc), .i_m0_wb_stb(m0_stb), .o_m0_wb_stall(m0_stall), .o_m0_wb_ack(m0_ack),
    .i_m0_wb_we(m0_we), .i_m0_wb_addr(m0_addr), .i_m0_wb_data(m0_wdat), .i_m0_wb_sel(m0_sel),
    .o_m0_wb_data(m0_rdat),
    .i_m1_wb_cyc(m1_cyc), .i_m1_wb_stb(m1_stb), .o_m1_wb_stall(m1_stall), .o_m1_wb_ack(m1_ack),
    .i_m1_wb_we(m1_we), .i_m1_wb_addr(m1_addr), .i_m1_wb_data(m1_wdat), .i_m1_wb_sel(m1_sel),
    .o_m1_wb_data(m1_rdat),
    .o_s_wb_cyc(s_cyc), .o_s_wb_stb(s_stb), .i_s_wb_stall(s_stall), .i_s_wb_ack(s_ack),
    .o_s_wb_we(s_we), .o_s_wb_addr(s_addr), .o_s_wb_data(s_wdat), .o_s_wb_sel(s_sel),
    .i_s_wb_data(s_rdat)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the bus, whether a dead turnaround cycle is
  // pending, who was served last, and how many requests are outstanding.
  int mo_owner;   // -1 none, else master index
  int mo_gap;
  int mo_last;
  int mo_out;

  // Pipelined memory slave model (never stalls, fixed ack latency).
  typedef struct {int due; logic [5:0] addr;} pend_t;
  pend_t       pend[$];
  logic [31:0] mem [0:63];
  int          ack_ws;
  bit          use_slave;
  int          cyc_n;
  int          acks0, acks1;
  logic [31:0] rd_q[$];

  typedef struct packed {logic [6:0] vin; logic [5:0] vexp;} vec_t;
  vec_t tbl [26];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive at negedge, compare at negedge+1, advance models.
  task automatic step(input logic r, input logic c0, input logic b0, input logic c1, input logic b1,
                      input logic sst, input logic sak, input bit use_tbl, input logic [5:0] tbl_exp,
                      input string tag);
    int         o;
    logic       cy, sb, sstb_e, st_e, ak_e;
    logic [5:0] ectl, actl;
    logic [66:0] edat, adat;
    @(negedge clk);
    rst_n = r; m0_cyc = c0; m0_stb = b0; m1_cyc = c1; m1_stb = b1;
    if (use_slave) begin
      s_stall = 1'b0;
      s_ack   = (pend.size() > 0) && (pend[0].due <= cyc_n);
      s_rdat  = s_ack ? mem[pend[0].addr] : 32'h0;
    end else begin
      s_stall = sst;
      s_ack   = sak;
      s_rdat  = $urandom;
    end
    #1;
    o = mo_owner;
    ectl = 6'b001100; edat = '0;
    cy = 1'b0; sb = 1'b0; sstb_e = 1'b0; st_e = 1'b1; ak_e = 1'b0;
    if (o >= 0) begin
      cy     = (o == 1) ? c1 : c0;
      sb     = (o == 1) ? b1 : b0;
      sstb_e = cy && sb && (mo_out < MAXO);
      st_e   = s_stall || (mo_out == MAXO);
      ak_e   = s_ack && (mo_out != 0);
      ectl   = (o == 1) ? {cy, sstb_e, 1'b1, st_e, 1'b0, ak_e} : {cy, sstb_e, st_e, 1'b1, ak_e, 1'b0};
      edat   = (o == 1) ? {m1_we, m1_addr, m1_wdat, m1_sel} : {m0_we, m0_addr, m0_wdat, m0_sel};
    end
    actl = {s_cyc, s_stb, m0_stall, m1_stall, m0_ack, m1_ack};
    adat = {s_we, s_addr, s_wdat, s_sel};
    check({tag, " ctl"}, 160'(actl), 160'(ectl));
    if (o >= 0) check({tag, " mux"}, 160'(adat), 160'(edat));
    check({tag, " rdata"}, 160'({m0_rdat, m1_rdat}), 160'({s_rdat, s_rdat}));
    if (use_tbl) check({tag, " table"}, 160'(actl), 160'(tbl_exp));
    if (m0_ack) begin acks0++; rd_q.push_back(m0_rdat); end
    if (m1_ack) begin acks1++; rd_q.push_back(m1_rdat); end
    if (use_slave) begin
      if (s_ack) void'(pend.pop_front());
      if (s_cyc && s_stb && !s_stall) begin
        if (s_we) begin
          for (int i = 0; i < 4; i++)
            if (s_sel[i]) mem[s_addr[5:0]][8*i +: 8] = s_wdat[8*i +: 8];
        end
        pend.push_back('{cyc_n + 1 + ack_ws, s_addr[5:0]});
      end
    end
    // model update
    if (!r) begin
      mo_owner = -1; mo_gap = 0; mo_last = 1; mo_out = 0;
    end else if (o >= 0) begin
      if (!cy) begin
        mo_owner = -1; mo_gap = 1; mo_out = 0;
      end else begin
        mo_out = mo_out + int'(sstb_e && !s_stall) - int'(ak_e);
      end
    end else if (mo_gap != 0) begin
      mo_gap = 0;
    end else if (c0 && c1) begin
      mo_owner = 1 - mo_last; mo_last = mo_owner;
    end else if (c0) begin
      mo_owner = 0; mo_last = 0;
    end else if (c1) begin
      mo_owner = 1; mo_last = 1;
    end
    cyc_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, "idle");
  endtask

  // Master m alone issues nreq requests and waits (bounded) for all acks.
  task automatic burst(input int m, input int nreq, input logic we, input logic [AW-1:0] a,
                       input logic [31:0] wd, output int max_out, output int cap_stalls,
                       output int grant_at);
    int   issued, acked, n;
    logic b, stl, ak;
    issued = 0; acked = 0; n = 0; max_out = 0; cap_stalls = 0; grant_at = -1;
    if (m == 0) begin m0_we = we; m0_addr = a; m0_wdat = wd; m0_sel = 4'hF; end
    else        begin m1_we = we; m1_addr = a; m1_wdat = wd; m1_sel = 4'hF; end
    while (acked < nreq && n < 200) begin
      b = (issued < nreq);
      step(1'b1, m == 0, (m == 0) && b, m == 1, (m == 1) && b, 1'b0, 1'b0, 1'b0, 6'd0, "burst");
      stl = (m == 0) ? m0_stall : m1_stall;
      ak  = (m == 0) ? m0_ack : m1_ack;
      if (s_cyc && grant_at < 0) grant_at = n;
      if (b && stl && s_cyc) cap_stalls++;
      if (b && !stl) issued++;
      if (ak) acked++;
      if (issued - acked > max_out) max_out = issued - acked;
      n++;
    end
    check("burst ack count", 160'(acked), 160'(nreq));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mx, cs, ga, a0, a1, gk;
    logic c0, c1;
    // {rst_n,m0cyc,m0stb,m1cyc,m1stb,s_stall,s_ack} -> {s_cyc,s_stb,stall0,stall1,ack0,ack1}
    tbl[0]  = '{7'b0000000, 6'b001100};  // reset
    tbl[1]  = '{7'b1101000, 6'b001100};  // tie seen in IDLE, no grant yet
    tbl[2]  = '{7'b1111100, 6'b110100};  // M0 owns, request accepted
    tbl[3]  = '{7'b1101101, 6'b100110};  // ack forwarded
    tbl[4]  = '{7'b1101101, 6'b100100};  // ack at cnt 0 discarded
    tbl[5]  = '{7'b1001100, 6'b000100};  // M0 drops cyc
    tbl[6]  = '{7'b1001100, 6'b001100};  // TURN
    tbl[7]  = '{7'b1001000, 6'b001100};  // IDLE
    tbl[8]  = '{7'b1001110, 6'b111100};  // M1 owns, slave stall
    tbl[9]  = '{7'b1001100, 6'b111000};  // cnt 0->1
    tbl[10] = '{7'b1001100, 6'b111000};  // 1->2
    tbl[11] = '{7'b1001100, 6'b111000};  // 2->3
    tbl[12] = '{7'b1001100, 6'b111000};  // 3->4
    tbl[13] = '{7'b1001100, 6'b101100};  // at cap: stb gated, stall
    tbl[14] = '{7'b1001101, 6'b101101};  // ack at cap
    tbl[15] = '{7'b1001101, 6'b111001};  // accept and ack together
    tbl[16] = '{7'b1000100, 6'b001000};  // M1 drops cyc with 3 outstanding, stb w/o cyc
    tbl[17] = '{7'b1101001, 6'b001100};  // TURN, late ack
    tbl[18] = '{7'b1101001, 6'b001100};  // IDLE, tie
    tbl[19] = '{7'b1101001, 6'b100100};  // M0 wins tie, late ack discarded
    tbl[20] = '{7'b0111000, 6'b110100};  // reset mid-burst
    tbl[21] = '{7'b1100000, 6'b001100};  // outputs at reset values
    tbl[22] = '{7'b1100000, 6'b100100};  // M0 alone granted
    tbl[23] = '{7'b1000000, 6'b000100};
    tbl[24] = '{7'b1000000, 6'b001100};
    tbl[25] = '{7'b1000000, 6'b001100};

    rst_n = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    m0_we = 1'b0; m0_addr = '0; m0_wdat = 32'h0; m0_sel = 4'h0;
    m1_we = 1'b0; m1_addr = '0; m1_wdat = 32'h0; m1_sel = 4'h0;
    s_stall = 1'b0; s_ack = 1'b0; s_rdat = 32'h0;
    use_slave = 1'b0; ack_ws = 0; cyc_n = 0; acks0 = 0; acks1 = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    repeat (2) @(posedge clk);
    mo_owner = -1; mo_gap = 0; mo_last = 1; mo_out = 0;

    for (int i = 0; i < 26; i++)
      step(tbl[i].vin[6], tbl[i].vin[5], tbl[i].vin[4], tbl[i].vin[3], tbl[i].vin[2],
           tbl[i].vin[1], tbl[i].vin[0], 1'b1, tbl[i].vexp, $sformatf("row%0d", i));

    // Write from M0 alone, single ack, grant one cycle after cyc.
    use_slave = 1'b1; pend.delete(); ack_ws = 0;
    a0 = acks0; a1 = acks1;
    burst(0, 1, 1'b1, 30'd15, 32'hAABBCCDD, mx, cs, ga);
    check("s1 grant latency", 160'(ga), 160'(1));
    check("s1 m0 acks", 160'(acks0 - a0), 160'(1));
    check("s1 m1 acks", 160'(acks1 - a1), 160'(0));
    check("s1 mem write", 160'(mem[15]), 160'(32'hAABBCCDD));
    idle(3);

    // Six back-to-back reads with slow acks hit the outstanding cap.
    ack_ws = 3; mem[16] = 32'h87654321; rd_q.delete();
    burst(1, 6, 1'b0, 30'd16, 32'h0, mx, cs, ga);
    check("s3 peak outstanding", 160'(mx), 160'(MAXO));
    check("s3 cap stall seen", 160'(cs > 0), 160'(1));
    check("s3 data count", 160'(rd_q.size()), 160'(6));
    foreach (rd_q[i]) check($sformatf("s3 data%0d", i), 160'(rd_q[i]), 160'(32'h87654321));
    idle(3);

    // M0 aborts with two requests outstanding; M1 waits then takes over.
    a0 = acks0; a1 = acks1;
    m0_we = 1'b0; m0_addr = 30'd16;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, "s4 tie");
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, "s4 req1");
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, "s4 req2");
    check("s4 outstanding", 160'(pend.size()), 160'(2));
    gk = -1;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, "s4 abort");
      if (s_cyc && gk < 0) gk = k;
    end
    check("s4 m1 grant cycle", 160'(gk), 160'(3));
    check("s4 late acks m0", 160'(acks0 - a0), 160'(0));
    check("s4 late acks m1", 160'(acks1 - a1), 160'(0));
    idle(3);

    // Read-back of M0's earlier write by M1.
    ack_ws = 0; rd_q.delete(); pend.delete();
    burst(1, 1, 1'b0, 30'd15, 32'h0, mx, cs, ga);
    check("s6 grant latency", 160'(ga), 160'(1));
    check("s6 readback", 160'(rd_q.size() > 0 ? rd_q[0] : 32'h0), 160'(32'hAABBCCDD));
    idle(3);

    // Randomized traffic against the reference model.
    use_slave = 1'b0;
    c0 = 1'b0; c1 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) c0 = ~c0;
      if ($urandom_range(0, 9) == 0) c1 = ~c1;
      m0_we = 1'($urandom); m0_addr = AW'($urandom); m0_wdat = $urandom; m0_sel = 4'($urandom);
      m1_we = 1'($urandom); m1_addr = AW'($urandom); m1_wdat = $urandom; m1_sel = 4'($urandom);
      step($urandom_range(0, 299) != 0, c0, 1'($urandom), c1, 1'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 1'b0, 6'd0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
